apb_uart_tx_queue: RTL and testbench

APB slave that sits directly downstream of the AXI-to-APB bridge and upstream of the UART transmitter.
- Decodes three registers: DATA, STATUS and CTRL.
- Buffers bytes written to DATA in a TX FIFO.
- A drain FSM hands bytes one at a time to the transmitter using a tx_start/tx_done handshake.
- Drives the UART static configuration: enable, baud select and parity.

---
 rtl/apb_uart_tx_queue.sv | 216 +++++++++++++++++++++
 tb/tb_apb_uart_tx_queue.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_tx_queue.sv
// APB register front-end for the UART transmitter: DATA/STATUS/CTRL decode,
// a TX byte FIFO and a drain FSM that feeds bytes over a tx_start/tx_done handshake.
module apb_uart_tx_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [7:0]  tx_data_out,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic        tx_active,
  output logic        tx_enable,
  output logic [1:0]  baud_rate,
  output logic [1:0]  parity_type,
  output logic        tx_fifo_empty,
  output logic        tx_fifo_full
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [4:0]    ctrl_reg;
  logic          overflow_reg;
  state_t        state_reg;
  state_t        state_next;
  logic          tx_start_reg;
  logic [7:0]    tx_data_reg;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic       access;
  logic [7:0] addr;
  logic       sel_data;
  logic       sel_status;
  logic       sel_ctrl;
  logic       addr_valid;
  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       pop;
  logic       overflow_set;
  logic       overflow_clr;
  logic       ctrl_wr;
  logic [31:0] status_word;
  logic [31:0] rdata;

  // Bits of the bus that carry no meaning for this block.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{PADDR[31:8], PWDATA[31:8]};

  // A transfer in progress while held in reset is not an access.
  assign access     = PSEL & PENABLE & areset_n;
  assign addr       = PADDR[7:0];
  assign sel_data   = (addr == ADDR_DATA);
  assign sel_status = (addr == ADDR_STATUS);
  assign sel_ctrl   = (addr == ADDR_CTRL);
  assign addr_valid = sel_data | sel_status | sel_ctrl;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(DEPTH));

  // Full is judged at the start of the cycle, so a same-cycle pop never rescues a push.
  assign push         = access & PWRITE & sel_data & ~fifo_full;
  assign overflow_set = access & PWRITE & sel_data & fifo_full;
  assign overflow_clr = access & PWRITE & sel_status & PWDATA[3];
  assign ctrl_wr      = access & PWRITE & sel_ctrl;

  always_comb begin
    status_word           = '0;
    status_word[0]        = fifo_empty;
    status_word[1]        = fifo_full;
    status_word[2]        = tx_active;
    status_word[3]        = overflow_reg;
    status_word[4]        = (state_reg != ST_IDLE);
    status_word[8 +: CW]  = count_reg;
  end

  always_comb begin
    rdata = '0;
    if (access && !PWRITE) begin
      if (sel_status) begin
        rdata = status_word;
      end else if (sel_ctrl) begin
        rdata = {27'b0, ctrl_reg};
      end
    end
  end

  assign PRDATA  = rdata;
  assign PREADY  = access;
  assign PSLVERR = access & (~addr_valid | overflow_set);

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ctrl_reg[0] && !fifo_empty && !tx_active) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg    <= ST_IDLE;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      tx_start_reg <= pop;
      if (pop) begin
        tx_data_reg <= fifo_mem[rd_ptr_reg];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping; storage itself carries no reset so it maps onto RAM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= PWDATA[7:0];
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      ctrl_reg     <= 5'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_reg <= PWDATA[4:0];
      end
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end else if (overflow_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign tx_start      = tx_start_reg;
  assign tx_data_out   = tx_data_reg;
  assign tx_enable     = ctrl_reg[0];
  assign baud_rate     = ctrl_reg[2:1];
  assign parity_type   = ctrl_reg[4:3];
  assign tx_fifo_empty = fifo_empty;
  assign tx_fifo_full  = fifo_full;

endmodule

// File: tb/tb_apb_uart_tx_queue.sv
// Self-checking bench for apb_uart_tx_queue: directed scenarios plus randomized
// fill/drain rounds checked against a queue-based model of the TX path.
module tb_apb_uart_tx_queue;

  localparam int DEPTH = 8;

  logic        aclk;
  logic        areset_n;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  tx_data_out;
  logic        tx_start;
  logic        tx_done;
  logic        tx_active;
  logic        tx_enable;
  logic [1:0]  baud_rate;
  logic [1:0]  parity_type;
  logic        tx_fifo_empty;
  logic        tx_fifo_full;

  int checks = 0;
  int errors = 0;

  // Transmitter model state (written only by the transmitter process)
  logic [7:0] rx_q[$];
  int         width_bad = 0;
  int         tx_delay  = 3;

  // Reference model of the register/FIFO view
  logic [7:0] model_q[$];
  logic [4:0] model_ctrl = 5'd0;
  bit         model_ovf  = 1'b0;

  apb_uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .aclk         (aclk),
    .areset_n     (areset_n),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
    .tx_data_out  (tx_data_out),
    .tx_start     (tx_start),
    .tx_done      (tx_done),
    .tx_active    (tx_active),
    .tx_enable    (tx_enable),
    .baud_rate    (baud_rate),
    .parity_type  (parity_type),
    .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_full (tx_fifo_full)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Transmitter: capture each started byte, then pulse tx_done after tx_delay cycles.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge aclk);
      if (tx_start === 1'b1) begin
        rx_q.push_back(tx_data_out);
        @(negedge aclk);
        if (tx_start !== 1'b0) width_bad++;
        repeat (tx_delay - 1) @(negedge aclk);
        tx_done = 1'b1;
        @(negedge aclk);
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status(int cnt, bit act, bit ovf, bit busy);
    return (32'(cnt) << 8) | (32'(busy) << 4) | (32'(ovf) << 3) | (32'(act) << 2)
         | (32'(cnt == DEPTH) << 1) | 32'(cnt == 0);
  endfunction

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
    @(negedge aclk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = {24'($urandom), addr}; PWDATA = data;
    @(negedge aclk);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge aclk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("APB WR addr=%02h data=%08h slverr=%0b", addr, data, err);
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err,
                          output logic rdy);
    @(negedge aclk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = {24'($urandom), addr}; PWDATA = $urandom;
    @(negedge aclk);
    PENABLE = 1'b1;
    #1 data = PRDATA; err = PSLVERR; rdy = PREADY;
    @(negedge aclk);
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("APB RD addr=%02h data=%08h slverr=%0b", addr, data, err);
  endtask

  task automatic wait_rx(input int target);
    int k = 0;
    while (rx_q.size() < target && k < 400) begin
      @(negedge aclk);
      k++;
    end
    repeat (12) @(negedge aclk);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e, r;
    areset_n = 1'b0; tx_active = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h4; PWDATA = 32'hFFFF_FFFF;
    repeat (2) @(negedge aclk);
    #1;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready: got %0b required 0", PREADY); end
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %08h required 0", PRDATA); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %0b required 0", PSLVERR); end
    checks++; if ({tx_start, tx_data_out} !== 9'h0) begin errors++; $display("FAIL reset_tx: start=%0b data=%02h required 0/00", tx_start, tx_data_out); end
    checks++; if ({parity_type, baud_rate, tx_enable} !== 5'h0) begin errors++; $display("FAIL reset_ctrl: got %02h required 00", {parity_type, baud_rate, tx_enable}); end
    checks++; if ({tx_fifo_full, tx_fifo_empty} !== 2'b01) begin errors++; $display("FAIL reset_flags: full/empty=%02b required 01", {tx_fifo_full, tx_fifo_empty}); end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1;
    apb_read(8'h04, d, e, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status: got %08h required 00000001", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d; logic e, r;
    apb_write(8'h08, 32'h0000_000B, e);
    model_ctrl = 5'h0B;
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ctrl_wr_err: got %0b required 0", e); end
    checks++; if ({tx_enable, baud_rate, parity_type} !== 5'b1_01_01) begin
      errors++; $display("FAIL ctrl_outputs: en=%0b baud=%02b par=%02b required 1/01/01", tx_enable, baud_rate, parity_type); end
    apb_read(8'h04, d, e, r);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ctrl_status: got %08h required 00000001", d); end
    apb_write(8'h08, 32'hFFFF_FFEB, e);
    apb_read(8'h08, d, e, r);
    checks++; if (d !== 32'h0B) begin errors++; $display("FAIL ctrl_readback: got %08h required 0000000b", d); end
  endtask

  task automatic test_single_byte();
    logic [31:0] d; logic e, r;
    int base = rx_q.size();
    tx_delay = 3;
    apb_write(8'h00, 32'h41, e);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL latency_early: tx_start=%0b required 0", tx_start); end
    @(negedge aclk);
    checks++; if (tx_start !== 1'b1 || tx_data_out !== 8'h41) begin
      errors++; $display("FAIL latency_start: start=%0b data=%02h required 1/41", tx_start, tx_data_out); end
    checks++; if (tx_fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %0b required 1", tx_fifo_empty); end
    @(negedge aclk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse: tx_start=%0b required 0", tx_start); end
    repeat (6) @(negedge aclk);
    apb_read(8'h04, d, e, r);
    checks++; if (d !== exp_status(0, 0, 0, 0)) begin errors++; $display("FAIL single_idle: status=%08h required %08h", d, exp_status(0, 0, 0, 0)); end
    checks++; if (rx_q.size() != base + 1) begin errors++; $display("FAIL single_count: frames=%0d required %0d", rx_q.size() - base, 1); end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic e, r;
    int base;
    apb_write(8'h08, 32'h0, e); model_ctrl = 5'h0;
    for (int i = 0; i < DEPTH; i++) begin
      apb_write(8'h00, 32'h10 + 32'(i), e);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL fill_err[%0d]: got %0b required 0", i, e); end
    end
    checks++; if (tx_fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b required 1", tx_fifo_full); end
    apb_read(8'h04, d, e, r);
    checks++; if (d !== exp_status(8, 0, 0, 0)) begin errors++; $display("FAIL fill_status: got %08h required %08h", d, exp_status(8, 0, 0, 0)); end
    apb_write(8'h00, 32'h18, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL ovf_err: got %0b required 1", e); end
    apb_read(8'h04, d, e, r);
    checks++; if (d !== exp_status(8, 0, 1, 0)) begin errors++; $display("FAIL ovf_status: got %08h required %08h", d, exp_status(8, 0, 1, 0)); end
    apb_write(8'h04, 32'h8, e);
    apb_read(8'h04, d, e, r);
    checks++; if (d !== exp_status(8, 0, 0, 0)) begin errors++; $display("FAIL ovf_clear: got %08h required %08h", d, exp_status(8, 0, 0, 0)); end
    base = rx_q.size();
    tx_delay = int'($urandom_range(1, 4));
    apb_write(8'h08, 32'h1, e); model_ctrl = 5'h1;
    wait_rx(base + DEPTH);
    checks++; if (rx_q.size() != base + DEPTH) begin errors++; $display("FAIL drain_count: frames=%0d required %0d", rx_q.size() - base, DEPTH); end
    for (int i = 0; i < DEPTH && base + i < rx_q.size(); i++) begin
      checks++; if (rx_q[base + i] !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL drain_byte[%0d]: got %02h required %02h", i, rx_q[base + i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_disable_mid_frame();
    logic [31:0] d; logic e, r;
    int base, k;
    apb_write(8'h08, 32'h0, e); model_ctrl = 5'h0;
    apb_write(8'h00, 32'h21, e);
    apb_write(8'h00, 32'h22, e);
    apb_write(8'h00, 32'h23, e);
    tx_delay = 25;
    base = rx_q.size();
    apb_write(8'h08, 32'h1, e);
    k = 0;
    while (rx_q.size() < base + 1 && k < 50) begin @(negedge aclk); k++; end
    apb_write(8'h08, 32'h0, e); model_ctrl = 5'h0;
    repeat (40) @(negedge aclk);
    checks++; if (rx_q.size() != base + 1) begin errors++; $display("FAIL disable_frames: got %0d required 1", rx_q.size() - base); end
    apb_read(8'h04, d, e, r);
    checks++; if (d !== exp_status(2, 0, 0, 0)) begin errors++; $display("FAIL disable_status: got %08h required %08h", d, exp_status(2, 0, 0, 0)); end
    tx_delay = 2;
    apb_write(8'h08, 32'h1, e); model_ctrl = 5'h1;
    wait_rx(base + 3);
    checks++; if (rx_q.size() != base + 3) begin errors++; $display("FAIL reenable_frames: got %0d required 3", rx_q.size() - base); end
    else begin
      checks++; if ({rx_q[base], rx_q[base + 1], rx_q[base + 2]} !== 24'h212223) begin
        errors++; $display("FAIL reenable_order: got %02h %02h %02h required 21 22 23", rx_q[base], rx_q[base + 1], rx_q[base + 2]); end
    end
  endtask

  task automatic test_bad_offset_and_tx_active();
    logic [31:0] d; logic e, r;
    logic [7:0] a;
    int base;
    apb_write(8'h0C, 32'hFFFF_FFFF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_wr_err: got %0b required 1", e); end
    apb_read(8'h0C, d, e, r);
    checks++; if (e !== 1'b1 || d !== 32'h0 || r !== 1'b1) begin
      errors++; $display("FAIL bad_rd: err=%0b data=%08h ready=%0b required 1/0/1", e, d, r); end
    apb_read(8'h00, d, e, r);
    checks++; if (e !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL data_rd: err=%0b data=%08h required 0/0", e, d); end
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      if (a == 8'h00 || a == 8'h04 || a == 8'h08) a = 8'h0C;
      apb_write(a, $urandom, e);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL rand_bad_err[%02h]: got %0b required 1", a, e); end
    end
    apb_read(8'h08, d, e, r);
    checks++; if (d !== {27'b0, model_ctrl}) begin errors++; $display("FAIL bad_ctrl_kept: got %08h required %08h", d, {27'b0, model_ctrl}); end
    apb_read(8'h04, d, e, r);
    checks++; if (d !== exp_status(0, 0, 0, 0)) begin errors++; $display("FAIL bad_status_kept: got %08h required %08h", d, exp_status(0, 0, 0, 0)); end
    base = rx_q.size();
    tx_active = 1'b1;
    apb_write(8'h00, 32'h5A, e);
    repeat (10) @(negedge aclk);
    checks++; if (rx_q.size() != base) begin errors++; $display("FAIL active_hold: frames=%0d required 0", rx_q.size() - base); end
    apb_read(8'h04, d, e, r);
    checks++; if (d !== exp_status(1, 1, 0, 0)) begin errors++; $display("FAIL active_status: got %08h required %08h", d, exp_status(1, 1, 0, 0)); end
    tx_active = 1'b0;
    wait_rx(base + 1);
    checks++; if (rx_q.size() != base + 1 || rx_q[rx_q.size() - 1] !== 8'h5A) begin
      errors++; $display("FAIL active_release: frames=%0d last=%02h required 1/5a", rx_q.size() - base, rx_q[rx_q.size() - 1]); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic e, r;
    int k, after;
    apb_write(8'h08, 32'h0, e);
    for (int i = 0; i < 4; i++) apb_write(8'h00, 32'h31 + 32'(i), e);
    tx_delay = 4;
    apb_write(8'h08, 32'h1F, e);
    k = 0;
    while (tx_start !== 1'b1 && k < 20) begin @(negedge aclk); k++; end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL areset_start_seen: tx_start=%0b required 1", tx_start); end
    #2 areset_n = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0 || tx_data_out !== 8'h0) begin
      errors++; $display("FAIL areset_tx: start=%0b data=%02h required 0/00", tx_start, tx_data_out); end
    checks++; if (tx_fifo_empty !== 1'b1 || {parity_type, baud_rate, tx_enable} !== 5'h0) begin
      errors++; $display("FAIL areset_state: empty=%0b ctrl=%02h required 1/00", tx_fifo_empty, {parity_type, baud_rate, tx_enable}); end
    model_ctrl = 5'h0; model_ovf = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1;
    after = rx_q.size();
    apb_write(8'h08, 32'h1, e); model_ctrl = 5'h1;
    repeat (20) @(negedge aclk);
    checks++; if (rx_q.size() != after) begin errors++; $display("FAIL areset_flushed: frames=%0d required 0", rx_q.size() - after); end
    apb_write(8'h00, 32'h77, e);
    wait_rx(after + 1);
    checks++; if (rx_q.size() != after + 1 || rx_q[rx_q.size() - 1] !== 8'h77) begin
      errors++; $display("FAIL areset_new: frames=%0d last=%02h required 1/77", rx_q.size() - after, rx_q[rx_q.size() - 1]); end
  endtask

  task automatic test_random();
    logic [31:0] d, v; logic e, r, exp_err;
    logic [7:0] a, b;
    int n, base, cnt;
    for (int round = 0; round < 8; round++) begin
      v = $urandom & 32'hFFFF_FFFE;
      apb_write(8'h08, v, e);
      model_ctrl = v[4:0];
      checks++; if ({parity_type, baud_rate, tx_enable} !== model_ctrl) begin
        errors++; $display("FAIL rnd_ctrl_out[%0d]: got %02h required %02h", round, {parity_type, baud_rate, tx_enable}, model_ctrl); end
      n = int'($urandom_range(0, 11));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          a = 8'($urandom);
          if (a == 8'h00 || a == 8'h04 || a == 8'h08) a = 8'hF0;
          apb_read(a, d, e, r);
          checks++; if (e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL rnd_bad[%02h]: err=%0b data=%08h required 1/0", a, e, d); end
        end
        b = 8'($urandom);
        exp_err = (model_q.size() >= DEPTH);
        apb_write(8'h00, {24'($urandom), b}, e);
        if (exp_err) model_ovf = 1'b1; else model_q.push_back(b);
        checks++; if (e !== exp_err) begin errors++; $display("FAIL rnd_push_err[%0d.%0d]: got %0b required %0b", round, i, e, exp_err); end
      end
      cnt = model_q.size();
      apb_read(8'h04, d, e, r);
      checks++; if (d !== exp_status(cnt, 0, model_ovf, 0)) begin
        errors++; $display("FAIL rnd_status[%0d]: got %08h required %08h", round, d, exp_status(cnt, 0, model_ovf, 0)); end
      v = $urandom;
      apb_write(8'h04, v, e);
      if (v[3]) model_ovf = 1'b0;
      apb_read(8'h04, d, e, r);
      checks++; if (d[3] !== model_ovf) begin errors++; $display("FAIL rnd_ovf_clr[%0d]: got %0b required %0b", round, d[3], model_ovf); end
      base = rx_q.size();
      tx_delay = int'($urandom_range(1, 4));
      v = $urandom | 32'h1;
      apb_write(8'h08, v, e);
      model_ctrl = v[4:0];
      wait_rx(base + cnt);
      checks++; if (rx_q.size() != base + cnt) begin
        errors++; $display("FAIL rnd_drain_count[%0d]: got %0d required %0d", round, rx_q.size() - base, cnt); end
      for (int i = 0; i < cnt && base + i < rx_q.size(); i++) begin
        b = model_q.pop_front();
        checks++; if (rx_q[base + i] !== b) begin
          errors++; $display("FAIL rnd_drain_byte[%0d.%0d]: got %02h required %02h", round, i, rx_q[base + i], b); end
      end
      model_q.delete();
      apb_read(8'h08, d, e, r);
      checks++; if (d !== {27'b0, model_ctrl}) begin errors++; $display("FAIL rnd_ctrl_rd[%0d]: got %08h required %08h", round, d, {27'b0, model_ctrl}); end
    end
  endtask

  initial begin
    areset_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0; tx_active = 1'b0;
    test_reset();
    test_ctrl();
    test_single_byte();
    test_overflow();
    test_disable_mid_frame();
    test_bad_offset_and_tx_active();
    test_async_reset();
    test_random();
    checks++; if (width_bad != 0) begin errors++; $display("FAIL start_width: %0d wide pulses, required 0", width_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
